// File: rtl/neg_unit_if.sv
// rtl/neg_unit_if.sv - operand/result handshake bundle for neg_unit
interface neg_unit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, in_a, mode, out_ready,
        input  in_ready, out_valid, out, ovf, zero
    );

    modport slave (
        input  in_valid, in_a, mode, out_ready,
        output in_ready, out_valid, out, ovf, zero
    );
endinterface

// File: rtl/neg_unit.sv
// rtl/neg_unit.sv - chunk-serial invert/negate/abs/pass unit
// Processes CHUNK bits per cycle LSB first, rippling the +1 carry between chunks.
module neg_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    neg_unit_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic             inv;
    logic             ovf_pend;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] out_q;
    logic             ovf_q;
    logic             zero_q;

    logic [CHUNK-1:0] chunk_in;
    logic [CHUNK-1:0] opnd;
    logic [CHUNK:0]   sum_ext;
    logic [WIDTH-1:0] full;

    // full is the accumulator with the current chunk already merged in
    always_comb begin
        chunk_in = a_q[idx*CHUNK +: CHUNK];
        opnd     = inv ? ~chunk_in : chunk_in;
        sum_ext  = {1'b0, opnd} + {{CHUNK{1'b0}}, carry};
        full     = acc;
        full[idx*CHUNK +: CHUNK] = sum_ext[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            inv      <= 1'b0;
            ovf_pend <= 1'b0;
            a_q      <= '0;
            acc      <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.in_a;
                        inv      <= (bus.mode == 2'b00) || (bus.mode == 2'b01) ||
                                    ((bus.mode == 2'b10) && bus.in_a[WIDTH-1]);
                        carry    <= (bus.mode == 2'b01) ||
                                    ((bus.mode == 2'b10) && bus.in_a[WIDTH-1]);
                        ovf_pend <= ((bus.mode == 2'b01) || (bus.mode == 2'b10)) &&
                                    (bus.in_a == {1'b1, {(WIDTH-1){1'b0}}});
                        idx      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= full;
                    if (idx == LAST) begin
                        // final carry-out is dropped: results wrap at WIDTH bits
                        carry  <= 1'b0;
                        idx    <= '0;
                        out_q  <= full;
                        zero_q <= (full == '0);
                        ovf_q  <= ovf_pend;
                        state  <= DONE;
                    end else begin
                        carry <= sum_ext[CHUNK];
                        idx   <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out       = out_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_neg_unit.sv
// tb/tb_neg_unit.sv - self-checking bench for neg_unit at CHUNK 1, 4 and 16
module tb_neg_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_a = 16'h0;
    logic [1:0]  mode = 2'b00;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    neg_unit_if #(.WIDTH(16)) if1 ();
    neg_unit_if #(.WIDTH(16)) if4 ();
    neg_unit_if #(.WIDTH(16)) if16 ();

    assign if1.in_valid   = in_valid;
    assign if1.in_a       = in_a;
    assign if1.mode       = mode;
    assign if1.out_ready  = out_ready;
    assign if4.in_valid   = in_valid;
    assign if4.in_a       = in_a;
    assign if4.mode       = mode;
    assign if4.out_ready  = out_ready;
    assign if16.in_valid  = in_valid;
    assign if16.in_a      = in_a;
    assign if16.mode      = mode;
    assign if16.out_ready = out_ready;

    neg_unit #(.WIDTH(16), .CHUNK(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    neg_unit #(.WIDTH(16), .CHUNK(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    neg_unit #(.WIDTH(16), .CHUNK(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    // index 0: CHUNK=1, 1: CHUNK=4, 2: CHUNK=16
    logic [2:0]  ov;
    logic [2:0]  rdy;
    logic [2:0]  of;
    logic [2:0]  zr;
    logic [15:0] o [3];
    assign ov  = {if16.out_valid, if4.out_valid, if1.out_valid};
    assign rdy = {if16.in_ready, if4.in_ready, if1.in_ready};
    assign of  = {if16.ovf, if4.ovf, if1.ovf};
    assign zr  = {if16.zero, if4.zero, if1.zero};
    assign o[0] = if1.out;
    assign o[1] = if4.out;
    assign o[2] = if16.out;

    int          lat [3] = '{16, 4, 1};
    logic        pend [3];
    int          cnt [3];
    logic [15:0] eo [3];
    logic        eovf [3];
    logic        ez [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic [15:0] a, input logic [1:0] m,
                         output logic [15:0] r, output logic v, output logic z);
        case (m)
            2'b00:   r = ~a;
            2'b01:   r = 16'h0 - a;
            2'b10:   r = a[15] ? 16'h0 - a : a;
            default: r = a;
        endcase
        v = ((m == 2'b01) || (m == 2'b10)) && (a == 16'h8000);
        z = (r == 16'h0);
    endtask

    // reference: tracks acceptance and elapsed cycles per instance
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                pend[k] = 1'b0;
                cnt[k]  = 0;
            end else if (in_valid && rdy[k]) begin
                model(in_a, mode, eo[k], eovf[k], ez[k]);
                pend[k] = 1'b1;
                cnt[k]  = 0;
            end else if (pend[k]) begin
                if (ov[k] && out_ready) pend[k] = 1'b0;
                else cnt[k]++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("out_valid_k%0d", k), ov[k], pend[k] && (cnt[k] >= lat[k]));
                chk($sformatf("in_ready_k%0d", k), rdy[k], !pend[k]);
                if (ov[k]) begin
                    chk($sformatf("out_k%0d", k), o[k], eo[k]);
                    chk($sformatf("ovf_k%0d", k), of[k], eovf[k]);
                    chk($sformatf("zero_k%0d", k), zr[k], ez[k]);
                end
            end
        end
    end

    // called at posedge+1; returns at posedge+1 once all three hold a result
    task automatic wait_all(output int lat4);
        lat4 = -1;
        for (int n = 0; n < 40; n++) begin
            if (ov[1] && lat4 < 0) lat4 = n;
            if (ov == 3'b111) break;
            @(posedge clk); #1;
        end
        if (ov != 3'b111) chk("wait_timeout", {29'd0, ov}, 32'h7);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [1:0] m, input bit lit,
                          input logic [15:0] xo, input logic xv, input logic xz);
        int l4;
        in_valid = 1'b1;
        in_a = a;
        mode = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 16'($urandom);
        mode = 2'($urandom);
        wait_all(l4);
        if (lit) begin
            chk("lit_out", o[1], xo);
            chk("lit_ovf", of[1], xv);
            chk("lit_zero", zr[1], xz);
            chk("lit_latency4", l4, 4);
        end
        consume();
    endtask

    initial begin
        int l4;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_out", o[k], 16'h0);
            chk("rst_ovf", of[k], 1'b0);
            chk("rst_zero", zr[k], 1'b0);
            chk("rst_out_valid", ov[k], 1'b0);
            chk("rst_in_ready", rdy[k], 1'b1);
        end
        rst_n = 1'b1;

        run_op(16'h00F0, 2'b00, 1, 16'hFF0F, 1'b0, 1'b0);
        run_op(16'h0001, 2'b01, 1, 16'hFFFF, 1'b0, 1'b0);
        run_op(16'h0000, 2'b01, 1, 16'h0000, 1'b0, 1'b1);
        run_op(16'hFFF6, 2'b10, 1, 16'h000A, 1'b0, 1'b0);
        run_op(16'h0007, 2'b10, 1, 16'h0007, 1'b0, 1'b0);
        run_op(16'h8000, 2'b10, 1, 16'h8000, 1'b1, 1'b0);
        run_op(16'h8000, 2'b01, 1, 16'h8000, 1'b1, 1'b0);
        run_op(16'h1234, 2'b11, 1, 16'h1234, 1'b0, 1'b0);
        run_op(16'h8000, 2'b00, 1, 16'h7FFF, 1'b0, 1'b0);
        run_op(16'h8000, 2'b11, 1, 16'h8000, 1'b0, 1'b0);
        run_op(16'hFFFF, 2'b00, 1, 16'h0000, 1'b0, 1'b1);

        // backpressure with in_valid held high throughout
        in_valid = 1'b1;
        in_a = 16'h0005;
        mode = 2'b01;
        @(posedge clk); #1;
        in_a = 16'h0003;
        mode = 2'b00;
        wait_all(l4);
        for (int c = 0; c < 3; c++) begin
            chk("bp_out_held", o[1], 16'hFFFB);
            chk("bp_in_ready", rdy[1], 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_idle_ready", rdy[1], 1'b1);
        chk("bp_idle_valid", ov[1], 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_accept", rdy[1], 1'b0);
        wait_all(l4);
        chk("bp_second_out", o[1], 16'hFFFC);
        consume();

        // reset while the CHUNK=4 unit is on chunk 2
        in_valid = 1'b1;
        in_a = 16'h0F0F;
        mode = 2'b01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("abort_out", o[k], 16'h0);
            chk("abort_ovf", of[k], 1'b0);
            chk("abort_zero", zr[k], 1'b0);
            chk("abort_valid", ov[k], 1'b0);
            chk("abort_ready", rdy[k], 1'b1);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            chk("abort_no_valid", {29'd0, ov}, 32'h0);
        end

        for (int i = 0; i < 30; i++) begin
            logic [15:0] ra;
            ra = (i % 7 == 0) ? 16'h8000 : 16'($urandom);
            run_op(ra, 2'($urandom), 0, 16'h0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/neg_unit.md
NEG_UNIT -- requirements
Module: neg_unit

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter CHUNK, default 4, bits processed per cycle; SHALL divide WIDTH exactly; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand/mode offered.
REQ-006 in_ready  output  1  unit can accept an operand.
REQ-007 in_a  input  WIDTH  operand, two's-complement.
REQ-008 mode  input  2  00 invert, 01 negate, 10 absolute value, 11 pass-through.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 out  output  WIDTH  result.
REQ-012 ovf  output  1  result not representable (negate/abs of most-negative value).
REQ-013 zero  output  1  out equals 0.

Function
REQ-014 FSM states IDLE, BUSY, DONE; only these three reachable.
REQ-015 in_ready SHALL be 1 in IDLE only; accept = in_valid & in_ready.
REQ-016 On accept: latch in_a and mode, chunk index := 0, go BUSY; mode/in_a changes afterwards have no effect.
REQ-017 Latched controls: inv = (mode==00) | (mode==01) | (mode==10 & in_a[WIDTH-1]); carry-in = (mode==01) | (mode==10 & in_a[WIDTH-1]).
REQ-018 Each BUSY cycle: result chunk[i] = (inv ? ~a_chunk[i] : a_chunk[i]) + carry, CHUNK-bit sum; carry register := carry-out; i := i+1, LSB chunk first.
REQ-019 After chunk NCHUNK-1 processed: go DONE, out_valid := 1; out_valid first visible exactly NCHUNK cycles after the accept edge (CHUNK==WIDTH gives 1).
REQ-020 Final carry-out discarded (WIDTH-bit wrap-around).
REQ-021 ovf := 1 iff mode in {01,10} and latched in_a == {1, WIDTH-1 zeros}; result then equals operand unchanged; ovf=0 for modes 00, 11.
REQ-022 zero := (out == 0), valid with out_valid.
REQ-023 DONE: out, ovf, zero, out_valid held stable while out_ready=0; out_valid & out_ready -> IDLE next edge, out_valid := 0.
REQ-024 in_valid during BUSY/DONE ignored (no accept, no state change).
REQ-025 out, ovf, zero retain last result in IDLE until next result completes; only out_valid qualifies them.
REQ-026 mode 11: out = in_a, same NCHUNK latency, ovf=0.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE, out=0, ovf=0, zero=0, out_valid=0, carry=0, chunk index=0, in_ready=1 (combinational from state).
REQ-028 Reset during BUSY or DONE aborts the operation; no partial result is ever presented with out_valid=1.
REQ-029 After rst_n deasserts, first accept possible on the first rising edge.

Verification (WIDTH=16, CHUNK=4)
REQ-030 Invert 0x00F0 -> out=0xFF0F, ovf=0, zero=0, out_valid first high 4 cycles after accept edge.
REQ-031 Negate 0x0001 -> 0xFFFF; negate 0x0000 -> 0x0000, zero=1, ovf=0 (carry ripples through all 4 chunks).
REQ-032 Abs 0xFFF6 -> 0x000A, ovf=0; abs 0x0007 -> 0x0007; abs 0x8000 -> 0x8000, ovf=1; negate 0x8000 -> 0x8000, ovf=1.
REQ-033 Backpressure: out_ready=0 for 3 cycles after out_valid, in_valid=1 throughout -> out stable, in_ready=0, no second accept; out_ready=1 -> IDLE next edge, next operand accepted the edge after.
REQ-034 Reset pulse at BUSY chunk 2 -> all outputs 0 immediately, in_ready=1; out_valid never asserted for aborted operand.
REQ-035 Parameter sweep CHUNK in {1,4,16}: random operands/modes match reference model; latency = 16, 4, 1 cycles respectively.
